// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the data-memory port arbiter.
//  Revision : 1.0
// ============================================================================
package mem_arb_pkg;

  typedef enum logic {
    CPU_PRI   = 1'b0,
    DMA_BURST = 1'b1
  } arb_state_e;

  localparam int unsigned C_PERIPH_BIT = 30;
  localparam int unsigned C_STAT_W     = 16;

endpackage
`default_nettype wire

// File: rtl/mem_arb_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_sat_cnt
//  Purpose  : Saturating up-counter with synchronous clear.
//  Revision : 1.0
// ============================================================================
module mem_arb_sat_cnt #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != MAX_VAL)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : CPU-priority arbiter for the data-memory port with bounded DMA
//             bursts; ARB_STATS_EN adds stall / DMA-beat statistics outputs.
//  Revision : 1.0
// ============================================================================
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [C_STAT_W-1:0] stat_stall,
  output logic [C_STAT_W-1:0] stat_dma
`endif
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int BURST_W  = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_MAX - 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP  = STARVE_W'(STARVE_MAX);
  localparam logic [BURST_W-1:0]  BURST_LAST  = BURST_W'(BURST_MAX - 1);

  arb_state_e          state_q, state_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [STARVE_W-1:0] starve_q;

  logic w_in_burst;
  logic w_dma_refused;
  logic w_burst_start;
  logic w_burst_end;

  assign w_in_burst = (state_q == DMA_BURST);

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (w_in_burst) begin
        dma_gnt = dma_req;
        cpu_gnt = cpu_req & ~dma_req;
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req & ~cpu_req;
      end
    end
  end

  assign cpu_stall     = cpu_req & ~cpu_gnt & ~reset;
  assign dma_err       = dma_gnt & dma_addr[C_PERIPH_BIT];
  assign w_dma_refused = dma_req & ~dma_gnt & ~reset;

  // The refusal that brings the count to STARVE_MAX opens the burst on the next cycle.
  assign w_burst_start = ~w_in_burst & w_dma_refused & (starve_q >= STARVE_LAST);
  assign w_burst_end   = w_in_burst & ~reset &
                         (~dma_req | (dma_gnt & (burst_q == BURST_LAST)));

  mem_arb_sat_cnt #(
    .WIDTH   (STARVE_W),
    .MAX_VAL (STARVE_TOP)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (dma_gnt | w_burst_end),
    .inc_i (w_dma_refused),
    .cnt_o (starve_q)
  );

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    if (w_burst_start) begin
      state_d = DMA_BURST;
      burst_d = '0;
    end else if (w_burst_end) begin
      state_d = CPU_PRI;
      burst_d = '0;
    end else if (w_in_burst && dma_gnt) begin
      burst_d = burst_q + BURST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CPU_PRI;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (cpu_gnt) begin
      mem_rd = ~cpu_wr;
      mem_wr = cpu_wr;
    end else if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      // Peripheral-space beats complete without touching memory.
      mem_rd    = ~dma_wr & ~dma_err;
      mem_wr    = dma_wr & ~dma_err;
    end
  end

  assign rdata = mem_rdata;

`ifdef ARB_STATS_EN
  mem_arb_sat_cnt #(
    .WIDTH   (C_STAT_W),
    .MAX_VAL ('1)
  ) u_stat_stall (
    .clk   (clk),
    .reset (reset),
    .clr_i (1'b0),
    .inc_i (cpu_stall),
    .cnt_o (stat_stall)
  );

  mem_arb_sat_cnt #(
    .WIDTH   (C_STAT_W),
    .MAX_VAL ('1)
  ) u_stat_dma (
    .clk   (clk),
    .reset (reset),
    .clr_i (1'b0),
    .inc_i (dma_gnt),
    .cnt_o (stat_dma)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Directed scoreboard bench for mem_bus_arbiter.
//  Revision : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_wr, cpu_gnt, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        dma_req, dma_wr, dma_gnt, dma_err;
  logic [31:0] dma_addr, dma_wdata;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;
`ifdef ARB_STATS_EN
  logic [15:0] stat_stall, stat_dma;
`endif

  localparam logic [31:0] CW = 32'h1111_1111;

  int n_cmp = 0;
  int n_bad = 0;

  logic [101:0] exp_q [$];
  string        name_q[$];
  logic [31:0]  mem   [0:255];

  mem_bus_arbiter #(
    .DATA_W(32), .ADDR_W(32), .STARVE_MAX(8), .BURST_MAX(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_err(dma_err),
    .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_stall(stat_stall), .stat_dma(stat_dma)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word-indexed memory model; reads are combinational on mem_addr.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check(input string nm, input logic [101:0] act, input logic [101:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [101:0] ex(input logic cg, cs, dg, de, mr, mw,
                                      input logic [31:0] a, wd, rd);
    return {cg, cs, dg, de, mr, mw, a, wd, rd};
  endfunction

  task automatic step(input logic rs, cr, cw, input logic [31:0] ca, cwd,
                      input logic dr, dw, input logic [31:0] da, dwd,
                      input logic [101:0] e, input string nm);
    @(posedge clk);
    #1;
    reset = rs;
    cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cwd;
    dma_req = dr; dma_wr = dw; dma_addr = da; dma_wdata = dwd;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [101:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, {cpu_gnt, cpu_stall, dma_gnt, dma_err, mem_rd, mem_wr,
                 mem_addr, mem_wdata, rdata}, e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [101:0] e_cpu;
    logic [101:0] e;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
    reset = 1'b1;
    cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_wr = 0; dma_addr = 0; dma_wdata = 0;
    e_cpu = ex(1, 0, 0, 0, 1, 0, 32'h10, CW, 32'hA500_0004);

    // Reset: every output forced low, rdata still passes through.
    for (int i = 0; i < 2; i++)
      step(1, 1, 0, 32'h10, CW, 1, 1, 32'h100, 32'h5,
           ex(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hA500_0000), "reset");

    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 32'h10, CW, 0, 0, 32'h0, 32'h0, e_cpu, "cpu_only");

    for (int i = 0; i < 6; i++)
      step(0, 0, 0, 32'h20, 32'h0, 1, 1, 32'h100 + 4*i, 32'hD000_0000 + i,
           ex(0, 0, 1, 0, 0, 1, 32'h100 + 4*i, 32'hD000_0000 + i, 32'hA500_0040 + i),
           "dma_only");
    step(0, 1, 0, 32'h104, 32'h0, 0, 0, 32'h0, 32'h0,
         ex(1, 0, 0, 0, 1, 0, 32'h104, 32'h0, 32'hD000_0001), "dma_readback");

    // Both requesting: 8 refused DMA cycles, 4-beat burst, repeat.
    for (int k = 0; k < 24; k++) begin
      if ((k % 12) < 8) e = e_cpu;
      else e = ex(0, 1, 1, 0, 0, 1, 32'h200, 32'hBEEF_0000,
                  (k == 8) ? 32'hA500_0080 : 32'hBEEF_0000);
      step(0, 1, 0, 32'h10, CW, 1, 1, 32'h200, 32'hBEEF_0000, e, "starve");
    end

    // Burst cut short after 2 beats, then starvation counts from zero again.
    for (int k = 0; k < 21; k++) begin
      if (k == 8 || k == 9 || k == 19)
        e = ex(0, 1, 1, 0, 0, 1, 32'h300, 32'hCAFE_0000,
               (k == 8) ? 32'hA500_00C0 : 32'hCAFE_0000);
      else e = e_cpu;
      step(0, 1, 0, 32'h10, CW, (k != 10 && k != 20), 1, 32'h300, 32'hCAFE_0000,
           e, "early_exit");
    end
    step(0, 0, 0, 32'h10, CW, 0, 0, 32'h0, 32'h0,
         ex(0, 0, 0, 0, 0, 0, 32'h10, CW, 32'hA500_0004), "idle");

    step(0, 0, 0, 32'h10, CW, 1, 1, 32'h4000_0000, 32'hDEAD_BEEF,
         ex(0, 0, 1, 1, 0, 0, 32'h4000_0000, 32'hDEAD_BEEF, 32'hA500_0000), "err_wr");
    step(0, 0, 0, 32'h10, CW, 1, 0, 32'h4000_0010, 32'h0,
         ex(0, 0, 1, 1, 0, 0, 32'h4000_0010, 32'h0, 32'hA500_0004), "err_rd");
    step(0, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
         ex(1, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'hA500_0000), "err_unchanged");

    // Reset lands on what would be the second burst beat.
    for (int k = 0; k < 19; k++) begin
      if (k == 9)
        e = ex(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hA500_0000);
      else if (k == 8 || k == 18)
        e = ex(0, 1, 1, 0, 0, 1, 32'h380, 32'h1234_0000,
               (k == 8) ? 32'hA500_00E0 : 32'h1234_0000);
      else e = e_cpu;
      step((k == 9), 1, 0, 32'h10, CW, 1, 1, 32'h380, 32'h1234_0000, e, "reset_mid_burst");
`ifdef ARB_STATS_EN
      if (k == 10) begin
        #2;
        check("stat_stall_cleared", {86'b0, stat_stall}, 102'b0);
        check("stat_dma_cleared",   {86'b0, stat_dma},   102'b0);
      end
`endif
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 102'(exp_q.size()), 102'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
